// File: rtl/spi_frame_reader_pkg.sv
// Shared definitions for the SPI frame reader: frame geometry, reader
// states and small address helpers.
package spi_frame_reader_pkg;

  // Display geometry; one bit per pixel, eight pixels packed per byte.
  localparam int FRAME_WIDTH     = 320;
  localparam int FRAME_HEIGHT    = 240;
  localparam int PIXELS_PER_BYTE = 8;
  localparam int FRAME_BYTES     = (FRAME_WIDTH * FRAME_HEIGHT) / PIXELS_PER_BYTE;

  // Pixel address width into the ping-pong buffer.
  localparam int ADDR_W = 17;

  // Number of idle cycles spent after an address change before the read
  // data is sampled (memory delivers data two cycles after the address).
  localparam logic [1:0] MEM_WAIT = 2'd2;

  // Reader states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } state_t;

  // Address of the next byte: one byte holds PIXELS_PER_BYTE pixels.
  function automatic logic [ADDR_W-1:0] next_byte_addr(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_W'(PIXELS_PER_BYTE);
  endfunction

endpackage

// File: rtl/spi_frame_reader_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus single-cycle
// rise/fall pulses derived from the synchronized level.
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];

  // Shift the raw input through the synchronizer and remember the previous settled level
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync[0] <= i_din;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_level;
    end
  end

  // Edge pulses come only from flopped, already-synchronized values
  always_comb begin
    o_rise = w_level & ~r_prev;
    o_fall = ~w_level & r_prev;
  end

endmodule

// File: rtl/spi_frame_reader.sv
// SPI slave that streams one 1-bpp frame out of the ping-pong buffer,
// MSB first, in SPI mode 0. Bytes are prefetched one ahead so that the
// memory latency never stalls the serial stream; once the frame is done
// only zero bytes are shifted out until chip select is released.
module spi_frame_reader #(
  parameter int FRAME_BYTES = spi_frame_reader_pkg::FRAME_BYTES,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        sck,
  input  logic        cs_n,
  output logic        miso,
  input  logic        buffer_ready,
  output logic [16:0] spi_rd_addr,
  input  logic [7:0]  spi_rd_data,
  output logic        busy,
  output logic        frame_sent
);

  import spi_frame_reader_pkg::*;

  localparam int              CNT_W    = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  // Synchronized edge pulses
  logic w_sck_fall;
  logic w_unused_sck_rise;
  logic w_cs_fall;
  logic w_cs_rise;

  // Registered state
  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_shreg;
  logic [7:0]          r_prefetch;
  logic [2:0]          r_bit_cnt;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [1:0]          r_fetch_wait;
  logic [1:0]          r_pf_wait;
  logic                r_pf_pending;
  logic                r_buf_ok;
  logic                r_miso;
  logic                r_busy;
  logic                r_frame_sent;

  // Next-state values
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [7:0]          w_shreg_nxt;
  logic [7:0]          w_prefetch_nxt;
  logic [2:0]          w_bit_cnt_nxt;
  logic [CNT_W-1:0]    w_byte_cnt_nxt;
  logic [1:0]          w_fetch_wait_nxt;
  logic [1:0]          w_pf_wait_nxt;
  logic                w_pf_pending_nxt;
  logic                w_buf_ok_nxt;
  logic                w_miso_nxt;
  logic                w_frame_sent_nxt;
  logic [7:0]          w_rd_byte;

  sync_edge_detect #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sck_sync (
    .i_clk    (clk),
    .i_nreset (nreset),
    .i_din    (sck),
    .o_rise   (w_unused_sck_rise),
    .o_fall   (w_sck_fall)
  );

  sync_edge_detect #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .i_clk    (clk),
    .i_nreset (nreset),
    .i_din    (cs_n),
    .o_rise   (w_cs_rise),
    .o_fall   (w_cs_fall)
  );

  // An empty buffer is served as all-zero pixels
  always_comb begin
    if (r_buf_ok) begin
      w_rd_byte = spi_rd_data;
    end else begin
      w_rd_byte = 8'h00;
    end
  end

  // Next-state and datapath decisions for the reader FSM
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_shreg_nxt      = r_shreg;
    w_prefetch_nxt   = r_prefetch;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_fetch_wait_nxt = r_fetch_wait;
    w_pf_wait_nxt    = r_pf_wait;
    w_pf_pending_nxt = r_pf_pending;
    w_buf_ok_nxt     = r_buf_ok;
    w_miso_nxt       = r_miso;
    w_frame_sent_nxt = 1'b0;

    // Prefetch pipeline: count down the memory latency, then capture
    if (r_pf_pending) begin
      if (r_pf_wait == 2'd0) begin
        w_prefetch_nxt   = w_rd_byte;
        w_pf_pending_nxt = 1'b0;
      end else begin
        w_pf_wait_nxt = r_pf_wait - 2'd1;
      end
    end else begin
      w_pf_pending_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt      = ST_FETCH;
          w_addr_nxt       = '0;
          w_byte_cnt_nxt   = '0;
          w_bit_cnt_nxt    = 3'd0;
          w_fetch_wait_nxt = 2'd0;
          w_shreg_nxt      = 8'h00;
          w_pf_pending_nxt = 1'b0;
          w_buf_ok_nxt     = buffer_ready;
          w_miso_nxt       = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // sck edges are deliberately ignored until the first byte is loaded
        if (r_fetch_wait == MEM_WAIT) begin
          w_shreg_nxt = w_rd_byte;
          w_miso_nxt  = w_rd_byte[7];
          w_state_nxt = ST_SHIFT;
          if (LAST_IDX != '0) begin
            w_addr_nxt       = next_byte_addr(r_addr);
            w_pf_pending_nxt = 1'b1;
            w_pf_wait_nxt    = MEM_WAIT;
          end else begin
            w_pf_pending_nxt = 1'b0;
          end
        end else begin
          w_fetch_wait_nxt = r_fetch_wait + 2'd1;
        end
      end

      ST_SHIFT: begin
        if (w_sck_fall) begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
            if (r_byte_cnt == LAST_IDX) begin
              // Last frame byte fully shifted: only zeros from here on
              w_frame_sent_nxt = 1'b1;
              w_state_nxt      = ST_PAD;
              w_addr_nxt       = '0;
              w_shreg_nxt      = 8'h00;
              w_prefetch_nxt   = 8'h00;
              w_pf_pending_nxt = 1'b0;
              w_miso_nxt       = 1'b0;
            end else begin
              w_shreg_nxt = r_prefetch;
              w_miso_nxt  = r_prefetch[7];
              // Never issue an address beyond the last frame byte
              if ((r_byte_cnt + CNT_W'(1)) != LAST_IDX) begin
                w_addr_nxt       = next_byte_addr(r_addr);
                w_pf_pending_nxt = 1'b1;
                w_pf_wait_nxt    = MEM_WAIT;
              end else begin
                w_pf_pending_nxt = 1'b0;
              end
            end
          end else begin
            w_shreg_nxt = {r_shreg[6:0], 1'b0};
            w_miso_nxt  = r_shreg[6];
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_PAD: begin
        if (w_sck_fall) begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          w_shreg_nxt   = 8'h00;
          w_miso_nxt    = 1'b0;
        end else begin
          w_state_nxt = ST_PAD;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_miso_nxt  = 1'b0;
      end
    endcase

    // Releasing chip select aborts whatever is in flight
    if (w_cs_rise) begin
      w_state_nxt      = ST_IDLE;
      w_shreg_nxt      = 8'h00;
      w_pf_pending_nxt = 1'b0;
      w_miso_nxt       = 1'b0;
    end else begin
      w_miso_nxt = w_miso_nxt;
    end
  end

  // State and datapath registers, cleared asynchronously by nreset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_shreg      <= 8'h00;
      r_prefetch   <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= '0;
      r_fetch_wait <= 2'd0;
      r_pf_wait    <= 2'd0;
      r_pf_pending <= 1'b0;
      r_buf_ok     <= 1'b0;
      r_miso       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_sent <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_shreg      <= w_shreg_nxt;
      r_prefetch   <= w_prefetch_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_fetch_wait <= w_fetch_wait_nxt;
      r_pf_wait    <= w_pf_wait_nxt;
      r_pf_pending <= w_pf_pending_nxt;
      r_buf_ok     <= w_buf_ok_nxt;
      r_miso       <= w_miso_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_sent <= w_frame_sent_nxt;
    end
  end

  assign miso        = r_miso;
  assign spi_rd_addr = r_addr;
  assign busy        = r_busy;
  assign frame_sent  = r_frame_sent;

endmodule

// File: tb/tb_spi_frame_reader.sv
// Randomized bench for spi_frame_reader: an MCU-like SPI master (mode 0,
// sck = clk/8), a two-cycle-latency buffer model, and a byte-level
// reference model of what the frame stream should contain.
module tb_spi_frame_reader;

  localparam int FB = 12;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        nreset;
  logic        sck;
  logic        cs_n;
  logic        miso;
  logic        buffer_ready;
  logic [16:0] spi_rd_addr;
  logic [7:0]  spi_rd_data;
  logic        busy;
  logic        frame_sent;

  int          total = 0;
  int          bad = 0;
  int          bits_fallen = 0;
  int          fs_rises = 0;
  int          fs_high = 0;
  int          fs_bits = 0;
  logic        fs_prev = 1'b0;
  logic [7:0]  mem_seed = 8'h00;
  logic [7:0]  mem_q1;
  logic [16:0] model_addr = 17'd0;

  always #5 clk = ~clk;

  spi_frame_reader #(
    .FRAME_BYTES (FB),
    .SYNC_STAGES (SS)
  ) u_dut (
    .clk          (clk),
    .nreset       (nreset),
    .sck          (sck),
    .cs_n         (cs_n),
    .miso         (miso),
    .buffer_ready (buffer_ready),
    .spi_rd_addr  (spi_rd_addr),
    .spi_rd_data  (spi_rd_data),
    .busy         (busy),
    .frame_sent   (frame_sent)
  );

  // Buffer model: byte n (address 8n) holds n[7:0] ^ seed, two cycles of latency
  always @(posedge clk) begin
    mem_q1      <= spi_rd_addr[10:3] ^ mem_seed;
    spi_rd_data <= mem_q1;
  end

  // frame_sent monitor: cumulative high cycles, rising edges and bit position
  always @(negedge clk) begin
    if (frame_sent === 1'b1) begin
      fs_high = fs_high + 1;
      if (fs_prev !== 1'b1) begin
        fs_rises = fs_rises + 1;
        fs_bits  = bits_fallen;
      end
    end
    fs_prev = frame_sent;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: the k-th byte the master should see in a transfer
  function automatic logic [7:0] exp_byte(input int k, input logic br, input logic [7:0] seed);
    if (k < FB && br) return 8'(k) ^ seed;
    else return 8'h00;
  endfunction

  // Reference: address on the bus while byte k is being served
  function automatic logic [16:0] exp_addr(input int k);
    if (k >= FB) return 17'd0;
    else if (k + 1 > FB - 1) return 17'(8 * (FB - 1));
    else return 17'(8 * (k + 1));
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One transfer: nbytes full bytes, then extra_bits of the next byte, then release cs_n
  task automatic run_xfer(input int nbytes, input int extra_bits, input logic br,
                          input logic [7:0] seed, input logic flip_br);
    int         rises0;
    int         high0;
    int         nb;
    logic [7:0] b;
    logic [7:0] e;
    rises0       = fs_rises;
    high0        = fs_high;
    bits_fallen  = 0;
    mem_seed     = seed;
    buffer_ready = br;
    wait_clk(1);
    cs_n = 1'b0;
    wait_clk(6);
    for (int k = 0; k <= nbytes; k++) begin
      nb = (k < nbytes) ? 8 : extra_bits;
      b  = 8'h00;
      for (int i = 0; i < nb; i++) begin
        wait_clk(4);
        b = {b[6:0], miso};
        if (i == 0) begin
          check("rd_addr", 32'(spi_rd_addr), 32'(exp_addr(k)));
          check("busy_xfer", 32'(busy), 32'd1);
        end
        if (flip_br && k == 1 && i == 4) buffer_ready = ~buffer_ready;
        sck = 1'b1;
        wait_clk(4);
        sck = 1'b0;
        bits_fallen++;
      end
      e = exp_byte(k, br, seed);
      if (k < nbytes) check("byte", 32'(b), 32'(e));
      else if (nb > 0) check("partial", 32'(b), 32'(e >> (8 - nb)));
    end
    wait_clk(4);
    model_addr = exp_addr(nbytes);
    check("addr_end", 32'(spi_rd_addr), 32'(model_addr));
    cs_n = 1'b1;
    wait_clk(SS + 1);
    check("busy_abort", 32'(busy), 32'd0);
    check("miso_abort", 32'(miso), 32'd0);
    wait_clk(6);
    if (nbytes >= FB) begin
      check("fs_count", 32'(fs_rises - rises0), 32'd1);
      check("fs_width", 32'(fs_high - high0), 32'd1);
      check("fs_pos", 32'(fs_bits), 32'(8 * FB));
    end else begin
      check("fs_none", 32'(fs_rises - rises0), 32'd0);
    end
  endtask

  // sck activity with cs_n high must not touch the reader
  task automatic sck_glitches(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      wait_clk($urandom_range(1, 3));
      check("glitch_miso", 32'(miso), 32'd0);
      sck = 1'b0;
      wait_clk($urandom_range(1, 3));
    end
    wait_clk(4);
    check("glitch_addr", 32'(spi_rd_addr), 32'(model_addr));
    check("glitch_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int rises0;
    nreset       = 1'b0;
    sck          = 1'b0;
    cs_n         = 1'b1;
    buffer_ready = 1'b0;
    wait_clk(3);
    check("rst_addr", 32'(spi_rd_addr), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fs", 32'(frame_sent), 32'd0);
    nreset = 1'b1;
    wait_clk(4);

    // First three bytes of an identity buffer
    run_xfer(3, 0, 1'b1, 8'h00, 1'b0);
    sck_glitches(6);

    // Whole frame plus two pad bytes
    run_xfer(FB + 2, 0, 1'b1, 8'($urandom), 1'b0);

    // Buffer not ready: all zero, busy held
    run_xfer(FB + 1, 0, 1'b0, 8'($urandom), 1'b0);

    // Abort after 3 bits of byte 5, then restart from address 0
    run_xfer(5, 3, 1'b1, 8'h00, 1'b0);
    run_xfer(2, 0, 1'b1, 8'h00, 1'b0);

    // Reset in the middle of a byte
    rises0   = fs_rises;
    mem_seed = 8'h5a;
    buffer_ready = 1'b1;
    cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 19; i++) begin
      wait_clk(4);
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
    wait_clk(2);
    #2;
    nreset = 1'b0;
    cs_n   = 1'b1;
    #1;
    check("mid_rst_addr", 32'(spi_rd_addr), 32'd0);
    check("mid_rst_miso", 32'(miso), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fs", 32'(frame_sent), 32'd0);
    wait_clk(3);
    nreset = 1'b1;
    wait_clk(4);
    model_addr = 17'd0;
    sck_glitches(5);
    check("mid_rst_nofs", 32'(fs_rises - rises0), 32'd0);

    // Random transfers, buffer_ready sometimes toggled mid-transfer
    for (int t = 0; t < 8; t++) begin
      run_xfer($urandom_range(1, FB + 2), $urandom_range(0, 7),
               ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    sck_glitches(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_reader.md
SPI_FRAME_READER -- requirements
Module: spi_frame_reader

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 9600, meaning bytes per frame (320x240 pixels, 1 bit per pixel, 8 pixels per byte).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for SPI inputs.
REQ-003 SHALL have port clk, input, 1, system clock; sole clock domain.
REQ-004 SHALL have port nreset, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port sck, input, 1, SPI clock from the MCU; mode 0; frequency at most clk/8.
REQ-006 SHALL have port cs_n, input, 1, SPI chip select, active-low.
REQ-007 SHALL have port miso, output, 1, serial pixel data, MSB first.
REQ-008 SHALL have port buffer_ready, input, 1, a completed frame exists in the ping-pong buffer.
REQ-009 SHALL have port spi_rd_addr, output, 17, pixel address into the ping-pong buffer, always a multiple of 8.
REQ-010 SHALL have port spi_rd_data, input, 8, byte returned for spi_rd_addr; valid 2 clk cycles after the address changes.
REQ-011 SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-012 SHALL have port frame_sent, output, 1, one-cycle pulse when the last frame byte has been fully shifted out.

Function
REQ-013 SHALL pass sck and cs_n through SYNC_STAGES flops each, and detect edges (falling cs_n, falling sck, rising cs_n) only on the synchronized signals.
REQ-014 SHALL implement the states IDLE, FETCH, SHIFT and PAD.
REQ-015 In IDLE, on a synchronized cs_n falling edge, SHALL set spi_rd_addr=0 and byte_cnt=0, and go to FETCH.
REQ-016 FETCH SHALL wait 2 cycles, load shreg from spi_rd_data (0x00 if buffer_ready=0), drive miso=shreg[7], and go to SHIFT.
REQ-017 When FETCH loads shreg, it SHALL also advance spi_rd_addr by 8 and capture the next byte into a prefetch register 2 cycles later.
REQ-018 In SHIFT, each synchronized sck falling edge SHALL shift shreg left by one and increment bit_cnt, which is 3 bits and wraps at 8.
REQ-019 On the 8th falling edge, SHALL load shreg from the prefetch register, increment byte_cnt, advance spi_rd_addr by 8, and refill the prefetch register 2 cycles later.
REQ-020 When byte_cnt reaches FRAME_BYTES, SHALL pulse frame_sent for exactly one cycle, go to PAD, and hold spi_rd_addr at 0.
REQ-021 In PAD, SHALL shift out 0x00 for every further byte and never wrap back to address 0 data.
REQ-022 A synchronized cs_n rising edge in any state SHALL abort the transfer: go to IDLE, busy=0, miso=0, with no frame_sent pulse unless the frame was already complete.
REQ-023 A cs_n falling edge and a rising edge are never adjacent within a sync window; cs_n high for less than 4 clk cycles is ignored.
REQ-024 busy SHALL be 1 in FETCH, SHIFT and PAD, and 0 in IDLE.
REQ-025 buffer_ready SHALL be sampled only at FETCH entry; a mid-transfer change SHALL not alter bytes already being served.
REQ-026 spi_rd_addr arithmetic SHALL be 17-bit unsigned; the maximum address issued is 8*(FRAME_BYTES-1)=76792.
REQ-027 sck edges occurring in IDLE or FETCH SHALL be ignored.

Reset
REQ-028 nreset low SHALL asynchronously force state=IDLE, spi_rd_addr=0, shreg=0, prefetch=0, bit_cnt=0, byte_cnt=0, miso=0, busy=0, frame_sent=0, and all synchronizer flops to sck=0, cs_n=1.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer; after release, the block SHALL wait for a fresh cs_n falling edge.

Structure
REQ-030 A shared package SHALL hold the state enum, FRAME_WIDTH=320, FRAME_HEIGHT=240, FRAME_BYTES and PIXELS_PER_BYTE=8.
REQ-031 SHALL contain one sub-module, sync_edge_detect (synchronizer plus rise/fall pulses), instantiated once each for sck and cs_n.

Verification
REQ-032 Reset, buffer_ready=1, memory model byte n = n[7:0], sck=clk/8 -> first 3 bytes on miso are 0x00, 0x01, 0x02, and spi_rd_addr steps 0, 8, 16, 24.
REQ-033 Full 9600-byte burst -> frame_sent pulses once, exactly one cycle, after the 8th falling edge of byte 9599; the following 2 bytes read 0x00.
REQ-034 buffer_ready=0 at cs_n fall -> all bytes read 0x00, busy=1 throughout.
REQ-035 cs_n raised after 3 bits of byte 5 -> IDLE within SYNC_STAGES+1 cycles, no frame_sent; the next transfer restarts at address 0 and returns 0x00.
REQ-036 nreset pulsed low mid-byte -> all outputs at reset values immediately; no miso activity until a new cs_n falling edge.
REQ-037 sck glitches while cs_n is high -> spi_rd_addr unchanged, busy=0.
